// File: rtl/flight_cntrl_pkg.sv
// Shared constants, fixed-point types and saturation helpers for the flight_cntrl PD mixer.
// Optional simulation assertions are enabled by defining FLGHT_CNTRL_ASSERT_EN.
package flight_cntrl_pkg;

  localparam int          D_QUEUE_DEPTH = 14;
  localparam logic [12:0] MIN_RUN_SPEED = 13'h200;
  localparam logic [10:0] CAL_SPEED     = 11'h1B0;
  localparam int          DTERM         = 7;

  localparam int ERR_W   = 10;
  localparam int DDIFF_W = 6;
  localparam int PTERM_W = 10;
  localparam int DTERM_W = 12;
  localparam int MIX_W   = 13;

  typedef logic signed [ERR_W-1:0]   err_sat_t;
  typedef logic signed [DDIFF_W-1:0] ddiff_t;
  typedef logic signed [PTERM_W-1:0] pterm_t;
  typedef logic signed [DTERM_W-1:0] dterm_t;
  typedef logic signed [MIX_W-1:0]   mix_t;

  function automatic err_sat_t sat_err(input logic signed [16:0] v);
    if (v > 17'sd511) return 10'sh1FF;
    else if (v < -17'sd512) return 10'sh200;
    else return v[9:0];
  endfunction

  function automatic ddiff_t sat_ddiff(input logic signed [10:0] v);
    if (v > 11'sd31) return 6'sh1F;
    else if (v < -11'sd32) return 6'sh20;
    else return v[5:0];
  endfunction

  function automatic logic [10:0] sat_u11(input mix_t v);
    if (v < 13'sd0) return 11'h000;
    else if (v > 13'sd2047) return 11'h7FF;
    else return v[10:0];
  endfunction

endpackage

// File: rtl/flight_cntrl_axis_pd.sv
// One axis of the PD controller: saturated error, 5/8 proportional term, and a derivative
// taken against the oldest entry of a vld-advanced error history. FLGHT_CNTRL_ASSERT_EN adds range checks.
module axis_pd #(
  parameter int D_QUEUE_DEPTH = flight_cntrl_pkg::D_QUEUE_DEPTH,
  parameter int DTERM         = flight_cntrl_pkg::DTERM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_vld,
  input  logic [15:0]               i_des,
  input  logic [15:0]               i_meas,
  output flight_cntrl_pkg::pterm_t  o_pterm,
  output flight_cntrl_pkg::dterm_t  o_dterm
);
  import flight_cntrl_pkg::*;

  logic signed [16:0] w_err;
  err_sat_t           w_err_sat;
  err_sat_t           w_oldest;
  logic signed [10:0] w_diff;
  ddiff_t             w_ddiff;
  err_sat_t           r_queue [D_QUEUE_DEPTH];

  // 17-bit difference so full-scale opposite-sign inputs cannot wrap
  assign w_err     = $signed({i_meas[15], i_meas}) - $signed({i_des[15], i_des});
  assign w_err_sat = sat_err(w_err);
  assign o_pterm   = (w_err_sat >>> 1) + (w_err_sat >>> 3);

  assign w_oldest = r_queue[D_QUEUE_DEPTH-1];
  assign w_diff   = $signed({w_err_sat[9], w_err_sat}) - $signed({w_oldest[9], w_oldest});
  assign w_ddiff  = sat_ddiff(w_diff);
  assign o_dterm  = dterm_t'(w_ddiff) * dterm_t'(DTERM);

  // Error history: shifts only on valid samples, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) r_queue[i] <= {ERR_W{1'b0}};
    end else if (i_vld) begin
      r_queue[0] <= w_err_sat;
      for (int i = 1; i < D_QUEUE_DEPTH; i++) r_queue[i] <= r_queue[i-1];
    end
  end

`ifdef FLGHT_CNTRL_ASSERT_EN
  a_dterm_range: assert property (@(posedge clk) (o_dterm >= -12'sd224) && (o_dterm <= 12'sd217));
  a_pterm_range: assert property (@(posedge clk) (o_pterm >= -10'sd320) && (o_pterm <= 10'sd318));
`else
`endif

endmodule

// File: rtl/flight_cntrl.sv
// Quadcopter PD mixer top: three axis_pd instances mixed with thrust into four saturated
// 11-bit motor speeds, overridden during inertial calibration. FLGHT_CNTRL_ASSERT_EN adds checks.
module flight_cntrl #(
  parameter int          D_QUEUE_DEPTH = flight_cntrl_pkg::D_QUEUE_DEPTH,
  parameter logic [12:0] MIN_RUN_SPEED = flight_cntrl_pkg::MIN_RUN_SPEED,
  parameter logic [10:0] CAL_SPEED     = flight_cntrl_pkg::CAL_SPEED,
  parameter int          DTERM         = flight_cntrl_pkg::DTERM
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic        inertial_cal,
  input  logic [15:0] d_ptch,
  input  logic [15:0] d_roll,
  input  logic [15:0] d_yaw,
  input  logic [15:0] ptch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  input  logic [8:0]  thrst,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd
);
  import flight_cntrl_pkg::*;

  pterm_t w_ptch_pterm, w_roll_pterm, w_yaw_pterm;
  dterm_t w_ptch_dterm, w_roll_dterm, w_yaw_dterm;
  mix_t   w_base, w_ptch_corr, w_roll_corr, w_yaw_corr;
  mix_t   w_frnt, w_bck, w_lft, w_rght;

  axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .DTERM(DTERM)) u_ptch (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_des(d_ptch), .i_meas(ptch),
    .o_pterm(w_ptch_pterm), .o_dterm(w_ptch_dterm));
  axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .DTERM(DTERM)) u_roll (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_des(d_roll), .i_meas(roll),
    .o_pterm(w_roll_pterm), .o_dterm(w_roll_dterm));
  axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH), .DTERM(DTERM)) u_yaw (
    .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_des(d_yaw), .i_meas(yaw),
    .o_pterm(w_yaw_pterm), .o_dterm(w_yaw_dterm));

  assign w_base      = $signed(MIN_RUN_SPEED + {4'b0000, thrst});
  assign w_ptch_corr = mix_t'(w_ptch_pterm) + mix_t'(w_ptch_dterm);
  assign w_roll_corr = mix_t'(w_roll_pterm) + mix_t'(w_roll_dterm);
  assign w_yaw_corr  = mix_t'(w_yaw_pterm) + mix_t'(w_yaw_dterm);

  assign w_frnt = w_base - w_ptch_corr - w_yaw_corr;
  assign w_bck  = w_base + w_ptch_corr - w_yaw_corr;
  assign w_lft  = w_base - w_roll_corr + w_yaw_corr;
  assign w_rght = w_base + w_roll_corr + w_yaw_corr;

  // Calibration overrides the mix but the error queues keep running underneath
  assign frnt_spd = inertial_cal ? CAL_SPEED : sat_u11(w_frnt);
  assign bck_spd  = inertial_cal ? CAL_SPEED : sat_u11(w_bck);
  assign lft_spd  = inertial_cal ? CAL_SPEED : sat_u11(w_lft);
  assign rght_spd = inertial_cal ? CAL_SPEED : sat_u11(w_rght);

`ifdef FLGHT_CNTRL_ASSERT_EN
  a_cal_speed: assert property (@(posedge clk) inertial_cal |->
    ((frnt_spd == CAL_SPEED) && (bck_spd == CAL_SPEED) &&
     (lft_spd == CAL_SPEED) && (rght_spd == CAL_SPEED)));
`else
`endif

endmodule

// File: tb/tb_flight_cntrl.sv
// Directed self-checking bench for flight_cntrl with hand-computed motor speeds.
module tb_flight_cntrl;

  logic        clk = 1'b0;
  logic        rst_n, vld, inertial_cal;
  logic [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
  logic [8:0]  thrst;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;

  int n_tests = 0;
  int n_fail  = 0;

  flight_cntrl dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .inertial_cal(inertial_cal),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .ptch(ptch), .roll(roll), .yaw(yaw), .thrst(thrst),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [10:0] ef, input logic [10:0] eb,
                        input logic [10:0] el, input logic [10:0] er);
    #1;
    check({tag, ".frnt"}, frnt_spd, ef);
    check({tag, ".bck"},  bck_spd,  eb);
    check({tag, ".lft"},  lft_spd,  el);
    check({tag, ".rght"}, rght_spd, er);
  endtask

  task automatic push();
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; inertial_cal = 1'b0;
    d_ptch = 16'h0000; d_roll = 16'h0000; d_yaw = 16'h0000;
    ptch = 16'h0000; roll = 16'h0000; yaw = 16'h0000; thrst = 9'h000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    inertial_cal = 1'b1;
    check4("cal", 11'h1B0, 11'h1B0, 11'h1B0, 11'h1B0); push();
    inertial_cal = 1'b0; thrst = 9'h123;
    check4("base", 11'h323, 11'h323, 11'h323, 11'h323); push();

    ptch = 16'h0010; check4("p010", 11'h2A9, 11'h39D, 11'h323, 11'h323); push();
    ptch = 16'h0080; check4("p080", 11'h1FA, 11'h44C, 11'h323, 11'h323); push();
    ptch = 16'h0220; check4("p220", 11'h10C, 11'h53A, 11'h323, 11'h323); push();
    ptch = 16'hFFF0; check4("pFFF0", 11'h39D, 11'h2A9, 11'h323, 11'h323); push();
    ptch = 16'hFF80; check4("pFF80", 11'h453, 11'h1F3, 11'h323, 11'h323); push();
    ptch = 16'hFDE0; check4("pFDE0", 11'h543, 11'h103, 11'h323, 11'h323); push();

    yaw = 16'hFF80; check4("yFF80", 11'h673, 11'h233, 11'h1F3, 11'h1F3); push();
    yaw = 16'hFE00; thrst = 9'h1E0;
    check4("yFE00", 11'h7FF, 11'h3E0, 11'h1C0, 11'h1C0); push();

    repeat (2) @(posedge clk);
    check4("hold", 11'h7FF, 11'h3E0, 11'h1C0, 11'h1C0);

    ptch = 16'h0000; yaw = 16'h0000; thrst = 9'h123;
    repeat (6) push();
    check4("hist16", 11'h393, 11'h2B3, 11'h323, 11'h323);
    push();
    check4("hist17", 11'h403, 11'h243, 11'h323, 11'h323);

    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check4("rst_hist", 11'h323, 11'h323, 11'h323, 11'h323);

    roll = 16'h0010; check4("r010", 11'h323, 11'h323, 11'h2A9, 11'h39D); push();
    roll = 16'h0080; check4("r080", 11'h323, 11'h323, 11'h1FA, 11'h44C); push();
    roll = 16'h0220; check4("r220", 11'h323, 11'h323, 11'h10C, 11'h53A); push();
    roll = 16'hFFF0; check4("rFFF0", 11'h323, 11'h323, 11'h39D, 11'h2A9); push();
    roll = 16'hFF80; check4("rFF80", 11'h323, 11'h323, 11'h453, 11'h1F3); push();
    roll = 16'hFDE0; check4("rFDE0", 11'h323, 11'h323, 11'h543, 11'h103); push();

    thrst = 9'h000; ptch = 16'h7FFF; d_ptch = 16'h8000; roll = 16'h7FFF;
    check4("clamp0", 11'h000, 11'h417, 11'h000, 11'h417); push();

    thrst = 9'h123; ptch = 16'h0000; d_ptch = 16'h0010; roll = 16'h0000;
    check4("dptch", 11'h39D, 11'h2A9, 11'h323, 11'h323);

    inertial_cal = 1'b1; thrst = 9'h1FF; ptch = 16'h7FFF; yaw = 16'h8000;
    check4("cal_ovr", 11'h1B0, 11'h1B0, 11'h1B0, 11'h1B0); push();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
